// File: rtl/dac_seq_arb.sv
// ============================================================================
//  Module   : dac_seq_arb
//  Purpose  : Two-requester round-robin arbiter feeding a delta-sigma DAC code
//             register, holding each accepted sample for a programmable dwell.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dac_seq_arb #(
    parameter int               WIDTH      = 8,
    parameter int               DWELL_W    = 24,
    parameter logic [WIDTH-1:0] RESET_CODE = '0
) (
    input  logic               CLK_i,
    input  logic               RST_i,
    input  logic               REQ0_VALID_i,
    input  logic [WIDTH-1:0]   REQ0_DATA_i,
    output logic               REQ0_READY_o,
    input  logic               REQ1_VALID_i,
    input  logic [WIDTH-1:0]   REQ1_DATA_i,
    output logic               REQ1_READY_o,
    input  logic [DWELL_W-1:0] DWELL_i,
    output logic [WIDTH-1:0]   DAC_o,
    output logic [1:0]         GRANT_o,
    output logic               BUSY_o
);

    localparam logic [0:0] c_idle = 1'b0;
    localparam logic [0:0] c_hold = 1'b1;

    logic [0:0]         r_state;
    logic               r_last;     // 1 = requester 1 was granted last
    logic [DWELL_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_dac;
    logic [1:0]         r_grant;

    logic               w_open;
    logic               w_pick0;
    logic               w_pick1;
    logic               w_xfer;
    logic [DWELL_W-1:0] w_dwell_load;

    // Requester 1 wins when alone, or on a tie when requester 0 went last.
    assign w_open       = (r_state == c_idle) && !RST_i;
    assign w_pick1      = REQ1_VALID_i && (!REQ0_VALID_i || !r_last);
    assign w_pick0      = REQ0_VALID_i && !w_pick1;
    assign REQ0_READY_o = w_open && w_pick0;
    assign REQ1_READY_o = w_open && w_pick1;
    assign w_xfer       = REQ0_READY_o || REQ1_READY_o;
    assign w_dwell_load = (DWELL_i == '0) ? DWELL_W'(1) : DWELL_i;

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            r_state <= c_idle;
            r_last  <= 1'b1;
            r_cnt   <= '0;
            r_dac   <= RESET_CODE;
            r_grant <= 2'b00;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_xfer) begin
                        r_state <= c_hold;
                        r_last  <= REQ1_READY_o;
                        r_cnt   <= w_dwell_load;
                        r_dac   <= REQ1_READY_o ? REQ1_DATA_i : REQ0_DATA_i;
                        r_grant <= REQ1_READY_o ? 2'b10 : 2'b01;
                    end
                end
                c_hold: begin
                    if (r_cnt <= DWELL_W'(1)) begin
                        r_state <= c_idle;
                    end else begin
                        r_cnt <= r_cnt - DWELL_W'(1);
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign DAC_o   = r_dac;
    assign GRANT_o = r_grant;
    assign BUSY_o  = (r_state == c_hold);

endmodule

`default_nettype wire

// File: tb/tb_dac_seq_arb.sv
// ============================================================================
//  Module   : tb_dac_seq_arb
//  Purpose  : Self-checking bench for dac_seq_arb with a cycle-level model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dac_seq_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        v0, v1;
    logic [7:0]  d0, d1;
    logic [23:0] dwell;
    logic        rdy0, rdy1;
    logic [7:0]  dac;
    logic [1:0]  grant;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        int         cyc;
        int         req;
        logic [7:0] data;
    } ev_t;
    ev_t evq[$];

    dac_seq_arb #(.WIDTH(8), .DWELL_W(24), .RESET_CODE(8'h00)) dut (
        .CLK_i(clk), .RST_i(rst),
        .REQ0_VALID_i(v0), .REQ0_DATA_i(d0), .REQ0_READY_o(rdy0),
        .REQ1_VALID_i(v1), .REQ1_DATA_i(d1), .REQ1_READY_o(rdy1),
        .DWELL_i(dwell), .DAC_o(dac), .GRANT_o(grant), .BUSY_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: remaining hold cycles, last winner, and the owned code.
    int         m_hold  = 0;
    int         m_last  = 1;
    logic [7:0] m_dac   = 8'h00;
    logic [1:0] m_grant = 2'b00;
    bit         m_valid = 0;
    int         cyc     = 0;

    always @(negedge clk) begin
        logic e_r0, e_r1;
        cyc++;
        e_r0 = 1'b0;
        e_r1 = 1'b0;
        if (!rst && m_hold == 0) begin
            if (v0 && v1) begin
                if (m_last == 1) e_r0 = 1'b1; else e_r1 = 1'b1;
            end else if (v0) e_r0 = 1'b1;
            else if (v1) e_r1 = 1'b1;
        end
        if (m_valid) begin
            chk("m_ready0", rdy0, e_r0);
            chk("m_ready1", rdy1, e_r1);
            chk("m_dac", dac, m_dac);
            chk("m_grant", grant, m_grant);
            chk("m_busy", busy, (m_hold > 0));
        end
        if (rst) begin
            m_valid = 1;
            m_hold  = 0;
            m_last  = 1;
            m_dac   = 8'h00;
            m_grant = 2'b00;
        end else if (m_hold > 0) begin
            m_hold--;
        end else if (e_r0 || e_r1) begin
            m_last  = e_r1 ? 1 : 0;
            m_dac   = e_r1 ? d1 : d0;
            m_grant = e_r1 ? 2'b10 : 2'b01;
            m_hold  = (dwell == 0) ? 1 : int'(dwell);
            evq.push_back('{cyc: cyc, req: m_last, data: m_dac});
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle;
        int n = 0;
        while (busy === 1'b1 && n < 50) begin
            tick;
            n++;
        end
        chk("idle_timeout", busy, 1'b0);
    endtask

    initial begin
        logic acc;
        int   n;
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0; dwell = '0;
        tick; tick;
        chk("rst_dac", dac, 8'h00);
        chk("rst_grant", grant, 2'b00);
        chk("rst_busy", busy, 1'b0);

        // Single request, dwell 3, accepted in the first cycle out of reset.
        v0 = 1'b1; d0 = 8'h40; dwell = 24'd3;
        #1 chk("rst_ready0_low", rdy0, 1'b0);
        rst = 1'b0;
        #1 chk("first_ready0", rdy0, 1'b1);
        tick;
        v0 = 1'b0;
        chk("acc_dac", dac, 8'h40);
        chk("acc_grant", grant, 2'b01);
        chk("acc_busy", busy, 1'b1);
        tick; tick;
        chk("busy_t3", busy, 1'b1);
        tick;
        chk("idle_t4", busy, 1'b0);

        // Contending requesters alternate, 3 cycles apart with dwell 2.
        rst = 1'b1; tick; rst = 1'b0;
        evq.delete();
        v0 = 1'b1; v1 = 1'b1; d0 = 8'h11; d1 = 8'h22; dwell = 24'd2;
        repeat (11) tick;
        chk("rr_count", evq.size(), 4);
        n = (evq.size() < 4) ? evq.size() : 4;
        for (int i = 0; i < n; i++) begin
            chk("rr_req", evq[i].req, i % 2);
            chk("rr_data", evq[i].data, (i % 2) ? 8'h22 : 8'h11);
            if (i > 0) chk("rr_space", evq[i].cyc - evq[i-1].cyc, 3);
        end
        v0 = 1'b0; v1 = 1'b0;
        wait_idle;

        // Dwell 0 acts as 1: accept every other cycle, data wraps.
        evq.delete();
        dwell = 24'd0; d1 = 8'hFD; v1 = 1'b1;
        repeat (8) begin
            #1 acc = rdy1;
            tick;
            if (acc) d1 = d1 + 8'd1;
        end
        chk("d0_count", evq.size(), 4);
        n = (evq.size() < 4) ? evq.size() : 4;
        for (int i = 0; i < n; i++) begin
            chk("d0_data", evq[i].data, 8'(8'hFD + i));
            if (i > 0) chk("d0_space", evq[i].cyc - evq[i-1].cyc, 2);
        end
        v1 = 1'b0;
        wait_idle;

        // Dwell changed mid-hold affects only the next hold.
        evq.delete();
        v0 = 1'b1; d0 = 8'h55; dwell = 24'd5;
        tick;
        dwell = 24'd1;
        repeat (9) tick;
        chk("dw_count", evq.size(), 3);
        if (evq.size() >= 3) begin
            chk("dw_hold5", evq[1].cyc - evq[0].cyc, 6);
            chk("dw_hold1", evq[2].cyc - evq[1].cyc, 2);
        end
        v0 = 1'b0;
        wait_idle;

        // Reset pulse in the middle of a hold.
        v0 = 1'b1; d0 = 8'h7F; dwell = 24'd10;
        tick;
        v0 = 1'b0;
        chk("ab_dac", dac, 8'h7F);
        v1 = 1'b1; d1 = 8'h33;
        tick; tick;
        rst = 1'b1;
        #1 chk("ab_rst_ready1", rdy1, 1'b0);
        tick;
        rst = 1'b0;
        chk("ab_dac_rst", dac, 8'h00);
        chk("ab_grant_rst", grant, 2'b00);
        chk("ab_busy_rst", busy, 1'b0);
        #1 chk("ab_ready1", rdy1, 1'b1);
        tick;
        v1 = 1'b0;
        chk("ab_dac_new", dac, 8'h33);
        chk("ab_grant_new", grant, 2'b10);

        // Long idle: code and owner hold.
        wait_idle;
        repeat (100) tick;
        chk("idle_dac", dac, 8'h33);
        chk("idle_grant", grant, 2'b10);
        chk("idle_busy", busy, 1'b0);
        chk("idle_ready0", rdy0, 1'b0);
        chk("idle_ready1", rdy1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
